// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. On an accepted start it computes
//   diff = (a - b - bI) mod 2^WIDTH and bO = borrow out of the MSB. It
//   processes one bit per clock, LSB first, then pulses done for one cycle.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   start  in   begin a subtraction (only looked at while idle)
//   a, b   in   WIDTH-bit unsigned minuend / subtrahend, captured on accept
//   bI     in   borrow-in, captured on accept
//   diff   out  WIDTH-bit result, valid with done and held until next accept
//   bO     out  final borrow, valid with diff
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when diff/bO become valid
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bI,
  output logic [WIDTH-1:0] diff,
  output logic             bO,
  output logic             busy,
  output logic             done
);

  // Counter holds 0..WIDTH, so it never wraps during an operation.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // One full-subtractor stage on the current LSBs.
  logic d_bit;
  logic br_next;

  always_comb begin
    d_bit   = a_q[0] ^ b_q[0] ^ br_q;
    br_next = (~a_q[0] & (b_q[0] | br_q)) | (b_q[0] & br_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bI;
          cnt_d   = '0;
          state_d = SHIFT;
          busy_d  = 1'b1;
        end
      end

      SHIFT: begin
        // New bit enters at the MSB; after WIDTH shifts bit 0 lands at diff[0].
        diff_d             = diff_q >> 1;
        diff_d[WIDTH-1]    = d_bit;
        a_d                = a_q >> 1;
        b_d                = b_q >> 1;
        br_d               = br_next;
        cnt_d              = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          bo_d    = br_next;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign diff = diff_q;
  assign bO   = bo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit instance driven with directed
// vectors, and a 4-bit instance driven exhaustively with back-to-back starts.
// A transaction-level reference tracks each instance and is compared every cycle.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, bi8, bo8, busy8, done8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bi4, bo4, busy4, done4;
  logic [3:0] a4, b4, diff4;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bI(bi8),
    .diff(diff8), .bO(bo8), .busy(busy8), .done(done8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bI(bi4),
    .diff(diff4), .bO(bo4), .busy(busy4), .done(done4)
  );

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int wid(input int i);
    return (i == 0) ? 8 : 4;
  endfunction
  function automatic logic sel_start(input int i);
    return (i == 0) ? start8 : start4;
  endfunction
  function automatic logic [32:0] sel_a(input int i);
    return (i == 0) ? 33'(a8) : 33'(a4);
  endfunction
  function automatic logic [32:0] sel_b(input int i);
    return (i == 0) ? 33'(b8) : 33'(b4);
  endfunction
  function automatic logic [32:0] sel_c(input int i);
    return (i == 0) ? 33'(bi8) : 33'(bi4);
  endfunction
  function automatic logic [7:0] ref_diff(input logic [32:0] a, input logic [32:0] b,
                                          input logic [32:0] c, input int w);
    return 8'((a - b - c) & ((33'd1 << w) - 33'd1));
  endfunction
  function automatic logic ref_bo(input logic [32:0] a, input logic [32:0] b,
                                  input logic [32:0] c);
    return a < (b + c);
  endfunction

  // k = edges since accept (0 = idle); busy for k in 1..W, done when k = W+1.
  int         k[2]  = '{0, 0};
  logic [7:0] ed[2] = '{8'd0, 8'd0};
  logic       eb[2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        k[i]  <= 0;
        ed[i] <= 8'd0;
        eb[i] <= 1'b0;
      end else if (k[i] == 0) begin
        if (sel_start(i)) begin
          k[i]  <= 1;
          ed[i] <= ref_diff(sel_a(i), sel_b(i), sel_c(i), wid(i));
          eb[i] <= ref_bo(sel_a(i), sel_b(i), sel_c(i));
        end
      end else if (k[i] == wid(i) + 1) begin
        k[i] <= 0;
      end else begin
        k[i] <= k[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy_w%0d", wid(i)), (i == 0) ? busy8 : busy4,
            (k[i] >= 1 && k[i] <= wid(i)));
        chk($sformatf("done_w%0d", wid(i)), (i == 0) ? done8 : done4,
            (k[i] == wid(i) + 1));
        if (k[i] == 0 || k[i] == wid(i) + 1) begin
          chk($sformatf("diff_w%0d", wid(i)), (i == 0) ? 32'(diff8) : 32'(diff4), ed[i]);
          chk($sformatf("bO_w%0d", wid(i)), (i == 0) ? bo8 : bo4, eb[i]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Called at a negedge while the 8-bit instance is idle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] xd, input logic xb, input string nm);
    int busy_cnt;
    int lat;
    bit seen;
    busy_cnt = 0;
    lat      = 0;
    seen     = 1'b0;
    start8 = 1'b1; a8 = a; b8 = b; bi8 = c;
    for (int t = 1; t <= 20 && !seen; t++) begin
      @(negedge clk);
      if (t == 1) begin
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
      end
      if (done8) begin
        seen = 1'b1;
        lat  = t;
      end else if (busy8) begin
        busy_cnt++;
      end
    end
    chk({nm, " done_seen"}, seen, 1);
    chk({nm, " latency"}, lat, 9);
    chk({nm, " busy_cycles"}, busy_cnt, 8);
    chk({nm, " diff"}, diff8, xd);
    chk({nm, " bO"}, bo8, xb);
    $display("op %s: a=%02h b=%02h bI=%0d -> diff=%02h bO=%0d", nm, a, b, c, diff8, bo8);
  endtask

  initial begin
    int done_cnt;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bi4 = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset diff8", diff8, 0);
    chk("reset bO8", bo8, 0);
    chk("reset busy8", busy8, 0);
    chk("reset done8", done8, 0);
    @(negedge clk);

    // Start presented on the very first edge with reset released.
    rst_n = 1'b1;
    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "05-03");
    @(negedge clk);
    op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "03-05");
    @(negedge clk);
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "00-00-1");
    @(negedge clk);
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "FF-FF-1");
    @(negedge clk);
    op8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, "80-7F-1");
    @(negedge clk);

    // start held and operands changed while shifting.
    done_cnt = 0;
    start8 = 1'b1; a8 = 8'h40; b8 = 8'h01; bi8 = 1'b0;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; bi8 = 1'b1;
    for (int t = 2; t <= 14; t++) begin
      @(negedge clk);
      if (done8) begin
        done_cnt++;
        chk("held-start diff", diff8, 8'h3F);
        chk("held-start bO", bo8, 0);
        start8 = 1'b0;
      end
    end
    chk("held-start done pulses", done_cnt, 1);
    $display("op held-start: a=40 b=01 bI=0 -> diff=%02h bO=%0d pulses=%0d", diff8, bo8, done_cnt);
    start8 = 1'b0;
    @(negedge clk);

    // Reset in the middle of an operation.
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h13; bi8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort diff8", diff8, 0);
    chk("abort bO8", bo8, 0);
    chk("abort busy8", busy8, 0);
    chk("abort done8", done8, 0);
    $display("op abort: reset mid-shift -> diff=%02h bO=%0d busy=%0d", diff8, bo8, busy8);
    repeat (12) @(negedge clk);
    op8(8'h5A, 8'h13, 1'b0, 8'h47, 1'b0, "5A-13 after abort");
    @(negedge clk);

    // 4-bit instance: one hand-checked vector, then every combination.
    start4 = 1'b1; a4 = 4'h3; b4 = 4'h9; bi4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (4) @(negedge clk);
    chk("w4 3-9-1 done", done4, 1);
    chk("w4 3-9-1 diff", diff4, 4'h9);
    chk("w4 3-9-1 bO", bo4, 1);
    $display("op w4 3-9-1: diff=%0h bO=%0d", diff4, bo4);
    @(negedge clk);

    for (int x = 0; x < 512; x++) begin
      start4 = 1'b1;
      a4  = 4'(x >> 5);
      b4  = 4'(x >> 1);
      bi4 = 1'(x & 1);
      @(negedge clk);
      a4 = 4'($urandom); b4 = 4'($urandom); bi4 = 1'($urandom);
      repeat (5) @(negedge clk);
      $display("op w4 #%0d: a=%0h b=%0h bI=%0d -> diff=%0h bO=%0d",
               x, 4'(x >> 5), 4'(x >> 1), x & 1, diff4, bo4);
    end
    start4 = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
